// File: rtl/spu_reg_file_mp.sv
// spu_reg_file_mp: multi-port register file with priority-resolved writes, registered
// reads and a hardware clear sweep. Optional same-cycle write forwarding: WR_BYPASS_EN.
module spu_reg_file_mp #(
  parameter int NUM_REGS    = 128,
  parameter int DATA_WD     = 128,
  parameter int NUM_RD      = 6,
  parameter int NUM_WR      = 2,
  parameter int CLR_PER_CYC = 4,
  parameter int RADDR_WD    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*RADDR_WD-1:0] rd_addr,
  output logic [NUM_RD*DATA_WD-1:0]  rd_data,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*RADDR_WD-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WD-1:0]  wr_data,
  input  logic                       clr_req,
  output logic                       rdy,
  output logic                       wr_conflict
);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nx;
  logic [RADDR_WD-1:0] clr_ptr, clr_ptr_nx;
  logic [DATA_WD-1:0]  mem [NUM_REGS];

  logic [RADDR_WD-1:0] ra [NUM_RD];
  logic [RADDR_WD-1:0] wa [NUM_WR];
  logic [DATA_WD-1:0]  wd [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;
  logic [DATA_WD-1:0]  rd_nx [NUM_RD];
  logic                conflict_nx;

  assign rdy = (state == RUN);

  // Writes are only live in RUN, outside a flush request, and for in-range addresses
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++)
      ra[p] = rd_addr[p*RADDR_WD +: RADDR_WD];
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wa[w]    = wr_addr[w*RADDR_WD +: RADDR_WD];
      wd[w]    = wr_data[w*DATA_WD +: DATA_WD];
      wr_ok[w] = wr_en[w] && (32'(wa[w]) < NUM_REGS) && (state == RUN) && !clr_req;
    end
  end

  always_comb begin
    conflict_nx = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++)
      for (int unsigned j = i + 1; j < NUM_WR; j++)
        if (wr_ok[i] && wr_ok[j] && (wa[i] == wa[j]))
          conflict_nx = 1'b1;
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_nx[p] = '0;
      if (32'(ra[p]) < NUM_REGS)
        rd_nx[p] = mem[ra[p]];
`ifdef WR_BYPASS_EN
      for (int unsigned w = 0; w < NUM_WR; w++)
        if (wr_ok[w] && (wa[w] == ra[p]))
          rd_nx[p] = wd[w];
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    case (state)
      INIT: begin
        if (clr_req) begin
          clr_ptr_nx = '0;
        end else if (clr_ptr == RADDR_WD'(NUM_REGS - CLR_PER_CYC)) begin
          state_nx   = RUN;
          clr_ptr_nx = '0;
        end else begin
          clr_ptr_nx = clr_ptr + RADDR_WD'(CLR_PER_CYC);
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nx   = INIT;
          clr_ptr_nx = '0;
        end
      end
      default: begin
        state_nx   = INIT;
        clr_ptr_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  // Array has no reset; INIT sweeps it to zero a group at a time
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int unsigned k = 0; k < CLR_PER_CYC; k++)
        mem[clr_ptr + RADDR_WD'(k)] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++)
        if (wr_ok[w])
          mem[wa[w]] <= wd[w];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict_nx;
      if (state == RUN) begin
        if (clr_req) begin
          rd_data <= '0;
        end else begin
          for (int unsigned p = 0; p < NUM_RD; p++)
            if (rd_en[p])
              rd_data[p*DATA_WD +: DATA_WD] <= rd_nx[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_spu_reg_file_mp.sv
// Self-checking bench for spu_reg_file_mp: reference array model plus a read scoreboard.
module tb_spu_reg_file_mp;
  localparam int NUM_REGS = 128;
  localparam int DATA_WD  = 128;
  localparam int NUM_RD   = 6;
  localparam int NUM_WR   = 2;
  localparam int AW       = 7;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*DATA_WD-1:0] rd_data;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*DATA_WD-1:0] wr_data;
  logic                    clr_req;
  logic                    rdy;
  logic                    wr_conflict;

  always #5 clk = ~clk;

  spu_reg_file_mp #(
    .NUM_REGS(NUM_REGS), .DATA_WD(DATA_WD), .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR), .CLR_PER_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .rdy(rdy), .wr_conflict(wr_conflict)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int                 port;
    logic [DATA_WD-1:0] exp;
  } sb_t;
  sb_t sb[$];

  logic [DATA_WD-1:0] m_mem [NUM_REGS];
  logic [DATA_WD-1:0] m_rd  [NUM_RD];

  function automatic logic [DATA_WD-1:0] dut_rd(int p);
    return rd_data[p*DATA_WD +: DATA_WD];
  endfunction
  function automatic logic [AW-1:0] get_wa(int w);
    return wr_addr[w*AW +: AW];
  endfunction
  function automatic logic [AW-1:0] get_ra(int p);
    return rd_addr[p*AW +: AW];
  endfunction
  function automatic logic [DATA_WD-1:0] get_wd(int w);
    return wr_data[w*DATA_WD +: DATA_WD];
  endfunction
  function automatic logic [DATA_WD-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
  endtask

  task automatic set_rd(int p, logic [AW-1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(int w, logic [AW-1:0] a, logic [DATA_WD-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*DATA_WD +: DATA_WD] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) m_mem[i] = '0;
    for (int p = 0; p < NUM_RD; p++) m_rd[p] = '0;
  endtask

  // One RUN-mode cycle: predict, push expectations, clock, pop and compare
  task automatic step_run(input string name);
    logic [DATA_WD-1:0] e;
    logic ec;
    sb_t s;
    ec = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_en[i] && wr_en[j] && get_wa(i) == get_wa(j)) ec = 1'b1;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        e = m_mem[get_ra(p)];
`ifdef WR_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++)
          if (wr_en[w] && get_wa(w) == get_ra(p)) e = get_wd(w);
`endif
        m_rd[p] = e;
      end
      s.port = p;
      s.exp  = m_rd[p];
      sb.push_back(s);
    end
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w]) m_mem[get_wa(w)] = get_wd(w);
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      checks++;
      if (dut_rd(s.port) !== s.exp) begin
        failures++;
        $display("FAIL %s rd_data[%0d] got=%h exp=%h", name, s.port, dut_rd(s.port), s.exp);
      end
    end
    checks++;
    if (wr_conflict !== ec) begin
      failures++;
      $display("FAIL %s wr_conflict got=%b exp=%b", name, wr_conflict, ec);
    end
  endtask

  // 32 edges of sweep: outputs quiet, rdy only after the last one
  task automatic wait_sweep(input string name);
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      checks++;
      if (rd_data !== '0) begin
        failures++;
        $display("FAIL %s rd_data_zero edge=%0d got=%h exp=0", name, e, rd_data);
      end
      checks++;
      if (rdy !== (e == 32)) begin
        failures++;
        $display("FAIL %s rdy edge=%0d got=%b exp=%b", name, e, rdy, (e == 32));
      end
      checks++;
      if (wr_conflict !== 1'b0) begin
        failures++;
        $display("FAIL %s wr_conflict edge=%0d got=%b exp=0", name, e, wr_conflict);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (rdy !== 1'b0 || rd_data !== '0 || wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL %s rdy/rd_data/wr_conflict got=%b/%h/%b exp=0/0/0", name, rdy, rd_data, wr_conflict);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    check_quiet("reset_state");
    rst = 1'b0;
    rd_en = '1;
    set_wr(0, 7'd3, rnd128());
    set_wr(1, 7'd3, rnd128());
    wait_sweep("reset_sweep");
    idle();
    model_clear();
    for (int base = 0; base < NUM_REGS; base += NUM_RD) begin
      for (int p = 0; p < NUM_RD; p++) set_rd(p, AW'((base + p) % NUM_REGS));
      step_run("read_all_zero");
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [DATA_WD-1:0] a5;
    a5 = {16{8'hA5}};
    idle(); set_wr(0, 7'd5, a5); step_run("wr_r5");
    idle(); set_rd(0, 7'd5); step_run("rd_r5");
    checks++;
    if (dut_rd(0) !== a5) begin
      failures++;
      $display("FAIL rd_r5_value got=%h exp=%h", dut_rd(0), a5);
    end
    idle(); rd_addr[0 +: AW] = 7'd7; step_run("rd_hold");
    checks++;
    if (dut_rd(0) !== a5) begin
      failures++;
      $display("FAIL rd_hold_value got=%h exp=%h", dut_rd(0), a5);
    end
    idle();
  endtask

  task automatic test_conflict();
    idle();
    set_wr(0, 7'd9, 128'h1);
    set_wr(1, 7'd9, 128'h2);
    step_run("conflict_wr");
    checks++;
    if (wr_conflict !== 1'b1) begin
      failures++;
      $display("FAIL conflict_pulse got=%b exp=1", wr_conflict);
    end
    idle(); step_run("conflict_drop");
    idle(); set_rd(1, 7'd9); step_run("conflict_rd");
    checks++;
    if (dut_rd(1) !== 128'h2) begin
      failures++;
      $display("FAIL conflict_winner got=%h exp=2", dut_rd(1));
    end
    idle();
  endtask

  task automatic test_same_cycle_rw();
    logic [DATA_WD-1:0] exp;
`ifdef WR_BYPASS_EN
    exp = 128'h3;
`else
    exp = 128'h0;
`endif
    idle();
    set_wr(0, 7'd12, 128'h3);
    set_rd(2, 7'd12);
    step_run("same_cycle_rw");
    checks++;
    if (dut_rd(2) !== exp) begin
      failures++;
      $display("FAIL same_cycle_value got=%h exp=%h", dut_rd(2), exp);
    end
    idle(); set_rd(2, 7'd12); step_run("rd_after_rw");
    idle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      idle();
      for (int w = 0; w < NUM_WR; w++)
        if ($urandom_range(0, 1) == 1) set_wr(w, AW'($urandom_range(0, 7)), rnd128());
      for (int p = 0; p < NUM_RD; p++)
        if ($urandom_range(0, 2) != 0) set_rd(p, AW'($urandom_range(0, 7)));
      step_run("back_to_back");
    end
    idle();
  endtask

  task automatic test_clear();
    idle(); set_wr(0, 7'd100, 128'hFF); step_run("clr_pre_wr");
    idle();
    clr_req = 1'b1;
    set_wr(0, 7'd3, 128'h77);
    set_wr(1, 7'd100, 128'h55);
    rd_en = '1;
    for (int p = 0; p < NUM_RD; p++) rd_addr[p*AW +: AW] = 7'd100;
    @(posedge clk); #1;
    check_quiet("clr_edge");
    clr_req = 1'b0;
    wr_en = '0;
    set_wr(1, 7'd101, 128'h99);
    wait_sweep("clr_sweep");
    idle();
    model_clear();
    set_rd(0, 7'd100); set_rd(1, 7'd3); set_rd(2, 7'd101);
    step_run("clr_readback");
    checks++;
    if (dut_rd(0) !== '0) begin
      failures++;
      $display("FAIL clr_r100 got=%h exp=0", dut_rd(0));
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    logic [DATA_WD-1:0] d;
    d = rnd128();
    idle(); set_wr(0, 7'd20, d); step_run("mid_pre_wr");
    idle(); set_rd(0, 7'd20); step_run("mid_pre_rd");
    idle();
    #3 rst = 1'b1;
    #1 check_quiet("rst_in_run");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
    end
    check_quiet("sweep_cycle10");
    #3 rst = 1'b1;
    #1 check_quiet("rst_mid_sweep");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_en = '1;
    wait_sweep("rst_mid_resweep");
    idle();
    model_clear();
    set_rd(0, 7'd20); step_run("mid_readback");
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_conflict();
    test_same_cycle_rw();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
